instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/tinymips_pkg.sv | 71 +++++++
 rtl/instr_fifo.sv | 68 ++++++
 rtl/instr_encoder.sv | 68 ++++++
 tb/tb_instr_encoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tinymips_pkg.sv
// Shared tinymips definitions: instruction kinds, opcode/funct fields,
// control bundle and the instruction word encoder.
package tinymips_pkg;

  typedef enum logic [3:0] {
    K_ADD = 4'd0,
    K_SUB = 4'd1,
    K_AND = 4'd2,
    K_OR  = 4'd3,
    K_SLT = 4'd4,
    K_LW  = 4'd5,
    K_SW  = 4'd6,
    K_BEQ = 4'd7
  } instr_kind_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [5:0] funct;
  } control_sig_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm
  );
    enc_t       e;
    logic [5:0] op;
    logic [5:0] fn;
    op      = OP_RTYPE;
    fn      = '0;
    e.legal = 1'b1;
    case (kind)
      K_ADD:   fn = FN_ADD;
      K_SUB:   fn = FN_SUB;
      K_AND:   fn = FN_AND;
      K_OR:    fn = FN_OR;
      K_SLT:   fn = FN_SLT;
      K_LW:    op = OP_LW;
      K_SW:    op = OP_SW;
      K_BEQ:   op = OP_BEQ;
      default: e.legal = 1'b0;
    endcase
    if (op == OP_RTYPE) e.word = {op, rs, rt, rd, 5'd0, fn};
    else                e.word = {op, rs, rt, imm};
    if (!e.legal)       e.word = '0;
    return e;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Power-of-two word queue with occupancy count.
// Head reads as zero whenever the queue is empty.
module instr_fifo
  import tinymips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder feeding an output word queue,
// with a sticky illegal-kind flag.
module instr_encoder
  import tinymips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [3:0]             IN_KIND,
  input  logic [4:0]             RS,
  input  logic [4:0]             RT,
  input  logic [4:0]             RD,
  input  logic [15:0]            IMM,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [31:0]            OUT_INSTR,
  output logic [$clog2(DEPTH):0] OCCUPANCY,
  output logic                   ERR,
  input  logic                   ERR_CLR
);

  enc_t enc;
  logic accept;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic err_q, err_d;

  assign enc       = encode(IN_KIND, RS, RT, RD, IMM);
  assign IN_READY  = ~full;
  assign OUT_VALID = ~empty;
  assign accept    = IN_VALID & IN_READY;
  assign push      = accept & enc.legal;
  assign pop       = OUT_VALID & OUT_READY;
  assign ERR       = err_q;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (pop),
    .wdata (enc.word),
    .rdata (OUT_INSTR),
    .count (OCCUPANCY),
    .full  (full),
    .empty (empty)
  );

  // A fresh illegal accept overrides a same-edge clear.
  always_comb begin
    err_d = err_q;
    if (ERR_CLR)              err_d = 1'b0;
    if (accept && !enc.legal) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= err_d;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder against a queue-based
// reference model of the encoder and its output buffer.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int FN[5] = '{32, 34, 36, 37, 42};
  localparam int OP[3] = '{35, 43, 4};

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [3:0]  IN_KIND = '0;
  logic [4:0]  RS = '0;
  logic [4:0]  RT = '0;
  logic [4:0]  RD = '0;
  logic [15:0] IMM = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_INSTR;
  logic [2:0]  OCCUPANCY;
  logic        ERR;
  logic        ERR_CLR = 1'b0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mq[$];
  logic        merr = 1'b0;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_KIND   (IN_KIND),
    .RS        (RS),
    .RT        (RT),
    .RD        (RD),
    .IMM       (IMM),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_INSTR (OUT_INSTR),
    .OCCUPANCY (OCCUPANCY),
    .ERR       (ERR),
    .ERR_CLR   (ERR_CLR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [32:0] ref_enc(
    input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [15:0] imm);
    if (kind < 4'd5)
      return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'(FN[kind])};
    if (kind < 4'd8)
      return {1'b1, 6'(OP[kind - 4'd5]), rs, rt, imm};
    return '0;
  endfunction

  function automatic logic [31:0] head();
    return (mq.size() != 0) ? mq[0] : 32'h0;
  endfunction

  task automatic set_req(input logic v, input logic [3:0] k,
    input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
    input logic [15:0] i);
    IN_VALID = v; IN_KIND = k; RS = s; RT = t; RD = d; IMM = i;
  endtask

  task automatic rand_legal();
    set_req(1'b1, 4'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
            5'($urandom), 16'($urandom));
  endtask

  // Advance one clock, updating the model with what the edge does.
  task automatic tick();
    bit          acc, pop;
    logic [32:0] e;
    acc = IN_VALID && (mq.size() < DEPTH);
    pop = OUT_READY && (mq.size() != 0);
    e   = ref_enc(IN_KIND, RS, RT, RD, IMM);
    @(posedge CLK);
    if (pop) void'(mq.pop_front());
    if (acc && e[32]) mq.push_back(e[31:0]);
    if (acc && !e[32]) merr = 1'b1;
    else if (ERR_CLR) merr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", OUT_VALID); end
    checks++; if (OCCUPANCY !== 3'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", OCCUPANCY); end
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", IN_READY); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", ERR); end
    checks++; if (OUT_INSTR !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", OUT_INSTR); end
    RST_N = 1'b1;
    tick();
    checks++; if (OUT_INSTR !== 32'h0) begin failures++; $display("FAIL post_rst_instr got=%h exp=0", OUT_INSTR); end
  endtask

  task automatic test_add();
    OUT_READY = 1'b1;
    set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h1234);
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL add_ready got=%b exp=1", IN_READY); end
    tick();
    IN_VALID = 1'b0;
    checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", OUT_VALID); end
    checks++; if (OUT_INSTR !== 32'h00221820) begin failures++; $display("FAIL add_instr got=%h exp=00221820", OUT_INSTR); end
    checks++; if (OCCUPANCY !== 3'd1) begin failures++; $display("FAIL add_occ got=%0d exp=1", OCCUPANCY); end
    tick();
    checks++; if (OCCUPANCY !== 3'd0) begin failures++; $display("FAIL add_drain got=%0d exp=0", OCCUPANCY); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  k[4]   = '{4'd5, 4'd6, 4'd7, 4'd4};
    logic [4:0]  s[4]   = '{5'd29, 5'd0, 5'd1, 5'd4};
    logic [4:0]  t[4]   = '{5'd8, 5'd5, 5'd2, 5'd5};
    logic [4:0]  d[4]   = '{5'd0, 5'd0, 5'd0, 5'd6};
    logic [15:0] im[4]  = '{16'h0004, 16'hFFFC, 16'hFFFF, 16'h0000};
    logic [31:0] ex[4]  = '{32'h8FA80004, 32'hAC05FFFC, 32'h1022FFFF, 32'h0085302A};
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, k[i], s[i], t[i], d[i], im[i]);
      tick();
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (OUT_INSTR !== ex[i]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, OUT_INSTR, ex[i]); end
      tick();
    end
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", OUT_VALID); end
  endtask

  task automatic test_full();
    logic [31:0] h0;
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_legal();
      tick();
    end
    h0 = head();
    checks++; if (OCCUPANCY !== 3'd4) begin failures++; $display("FAIL full_occ got=%0d exp=4", OCCUPANCY); end
    checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", IN_READY); end
    tick();
    checks++; if (OUT_INSTR !== h0) begin failures++; $display("FAIL full_hold got=%h exp=%h", OUT_INSTR, h0); end
    checks++; if (OCCUPANCY !== 3'd4) begin failures++; $display("FAIL full_occ2 got=%0d exp=4", OCCUPANCY); end
    OUT_READY = 1'b1;
    tick();
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL full_reopen got=%b exp=1", IN_READY); end
    checks++; if (OCCUPANCY !== 3'd3) begin failures++; $display("FAIL full_pop_occ got=%0d exp=3", OCCUPANCY); end
    OUT_READY = 1'b0;
    tick();
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (OUT_INSTR !== head()) begin failures++; $display("FAIL full_order%0d got=%h exp=%h", i, OUT_INSTR, head()); end
      tick();
    end
    checks++; if (OCCUPANCY !== 3'd0) begin failures++; $display("FAIL full_drain got=%0d exp=0", OCCUPANCY); end
  endtask

  task automatic test_err();
    OUT_READY = 1'b0;
    set_req(1'b1, 4'd9, 5'd1, 5'd2, 5'd3, 16'h0);
    tick();
    IN_VALID = 1'b0;
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", ERR); end
    checks++; if (OCCUPANCY !== 3'd0) begin failures++; $display("FAIL err_occ got=%0d exp=0", OCCUPANCY); end
    ERR_CLR = 1'b1;
    tick();
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", ERR); end
    set_req(1'b1, 4'd12, 5'd0, 5'd0, 5'd0, 16'h0);
    tick();
    IN_VALID = 1'b0;
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL err_setwins got=%b exp=1", ERR); end
    tick();
    ERR_CLR = 1'b0;
  endtask

  task automatic test_async_reset();
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_legal();
      tick();
    end
    IN_VALID = 1'b0;
    checks++; if (OCCUPANCY !== 3'd3) begin failures++; $display("FAIL ar_pre got=%0d exp=3", OCCUPANCY); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", OUT_VALID); end
    checks++; if (OCCUPANCY !== 3'd0) begin failures++; $display("FAIL ar_occ got=%0d exp=0", OCCUPANCY); end
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", IN_READY); end
    checks++; if (OUT_INSTR !== 32'h0) begin failures++; $display("FAIL ar_instr got=%h exp=0", OUT_INSTR); end
    mq.delete();
    merr = 1'b0;
    #2 RST_N = 1'b1;
    rand_legal();
    tick();
    IN_VALID = 1'b0;
    checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL ar_lat got=%b exp=1", OUT_VALID); end
    checks++; if (OUT_INSTR !== head()) begin failures++; $display("FAIL ar_word got=%h exp=%h", OUT_INSTR, head()); end
    OUT_READY = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    OUT_READY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_legal();
      tick();
    end
    OUT_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_legal();
      checks++; if (OUT_INSTR !== head()) begin failures++; $display("FAIL stream_word%0d got=%h exp=%h", i, OUT_INSTR, head()); end
      tick();
      checks++; if (OCCUPANCY !== 3'd2) begin failures++; $display("FAIL stream_occ%0d got=%0d exp=2", i, OCCUPANCY); end
    end
    IN_VALID = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      IN_KIND   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                              : 4'($urandom_range(0, 7));
      RS = 5'($urandom); RT = 5'($urandom); RD = 5'($urandom);
      IMM = 16'($urandom);
      OUT_READY = 1'($urandom);
      ERR_CLR   = ($urandom_range(0, 15) == 0);
      checks++; if (IN_READY !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready c=%0d got=%b", c, IN_READY); end
      tick();
      checks++; if (OUT_VALID !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_valid c=%0d got=%b", c, OUT_VALID); end
      checks++; if (OUT_INSTR !== head()) begin failures++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, OUT_INSTR, head()); end
      checks++; if (OCCUPANCY !== 3'(mq.size())) begin failures++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, OCCUPANCY, mq.size()); end
      checks++; if (ERR !== merr) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, ERR, merr); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_full();
    test_err();
    test_async_reset();
    test_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
